// File: rtl/h264recon_fifo.sv
// h264recon_fifo: prediction FIFO with full/empty flow control feeding a two-stage residual add and clip pipeline
module h264recon_fifo #(
  parameter int LANES     = 4,
  parameter int BIT_DEPTH = 8,
  parameter int RES_W     = 10,
  parameter int DEPTH     = 64
) (
  input  logic                         CLK2,
  input  logic                         RSTN,
  input  logic                         NEWSLICE,
  input  logic                         STROBEI,
  input  logic [LANES*RES_W-1:0]       DATAI,
  input  logic                         BSTROBEI,
  input  logic                         BCHROMAI,
  input  logic [LANES*BIT_DEPTH-1:0]   BASEI,
  output logic                         BREADYO,
  output logic                         DREADYO,
  output logic                         STROBEO,
  output logic                         CSTROBEO,
  output logic [LANES*BIT_DEPTH-1:0]   DATAO,
  output logic [$clog2(DEPTH):0]       LEVELO,
  output logic                         OVFO,
  output logic                         UNFO
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = LANES*BIT_DEPTH;
  localparam logic signed [RES_W:0] PMAX = (RES_W+1)'((1 << BIT_DEPTH) - 1);
  logic [PW:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [PW:0] head;
  logic clr, push, pop, s1_v, s1_c;
  logic [LANES-1:0][RES_W:0] sum, s1_sum;
  logic [PW-1:0] clip;
  assign clr = !RSTN || NEWSLICE;
  assign BREADYO = LEVELO != (AW+1)'(DEPTH);
  assign DREADYO = LEVELO != '0;
  assign push = BSTROBEI && BREADYO;
  assign pop = STROBEI && DREADYO;
  assign head = mem[rp];
  // sum is wide enough that base + residual never wraps; the top bit is the sign
  genvar i;
  generate
    for (i = 0; i < LANES; i++) begin : g_lane
      assign sum[i] = (RES_W+1)'(head[i*BIT_DEPTH +: BIT_DEPTH])
                    + {DATAI[i*RES_W+RES_W-1], DATAI[i*RES_W +: RES_W]};
      assign clip[i*BIT_DEPTH +: BIT_DEPTH] = s1_sum[i][RES_W] ? '0 :
                                              ($signed(s1_sum[i]) > PMAX) ? {BIT_DEPTH{1'b1}} :
                                              s1_sum[i][BIT_DEPTH-1:0];
    end
  endgenerate
  always_ff @(posedge CLK2)
    if (push && !clr) mem[wp] <= {BCHROMAI, BASEI};
  always_ff @(posedge CLK2) begin
    if (clr) begin
      wp       <= '0;
      rp       <= '0;
      LEVELO   <= '0;
      OVFO     <= 1'b0;
      UNFO     <= 1'b0;
      s1_v     <= 1'b0;
      s1_c     <= 1'b0;
      s1_sum   <= '0;
      STROBEO  <= 1'b0;
      CSTROBEO <= 1'b0;
      DATAO    <= '0;
    end else begin
      wp       <= wp + AW'(push);
      rp       <= rp + AW'(pop);
      LEVELO   <= LEVELO + (AW+1)'(push) - (AW+1)'(pop);
      OVFO     <= OVFO | (BSTROBEI && !BREADYO);
      UNFO     <= UNFO | (STROBEI && !DREADYO);
      s1_v     <= pop;
      s1_c     <= head[PW];
      s1_sum   <= sum;
      STROBEO  <= s1_v && !s1_c;
      CSTROBEO <= s1_v && s1_c;
      DATAO    <= s1_v ? clip : DATAO;
    end
  end
endmodule

// File: tb/tb_h264recon_fifo.sv
// tb_h264recon_fifo: directed stimulus against a queue-based reference model, checked every cycle
module tb_h264recon_fifo;
  localparam int LANES = 4, BD = 8, RW = 10, DEPTH = 64, LW = $clog2(DEPTH) + 1;
  localparam int PW = LANES*BD;
  logic CLK2 = 0, RSTN = 0, NEWSLICE = 0, STROBEI = 0, BSTROBEI = 0, BCHROMAI = 0;
  logic [LANES*RW-1:0] DATAI = '0;
  logic [PW-1:0] BASEI = '0;
  logic BREADYO, DREADYO, STROBEO, CSTROBEO, OVFO, UNFO;
  logic [PW-1:0] DATAO;
  logic [LW-1:0] LEVELO;
  h264recon_fifo #(.LANES(LANES), .BIT_DEPTH(BD), .RES_W(RW), .DEPTH(DEPTH)) dut (
    .CLK2(CLK2), .RSTN(RSTN), .NEWSLICE(NEWSLICE), .STROBEI(STROBEI), .DATAI(DATAI),
    .BSTROBEI(BSTROBEI), .BCHROMAI(BCHROMAI), .BASEI(BASEI), .BREADYO(BREADYO),
    .DREADYO(DREADYO), .STROBEO(STROBEO), .CSTROBEO(CSTROBEO), .DATAO(DATAO),
    .LEVELO(LEVELO), .OVFO(OVFO), .UNFO(UNFO));
  always #5 CLK2 = ~CLK2;
  int vecs = 0, errs = 0;
  logic [PW:0] mq [$];
  bit m_ov, m_un, p1_v, p1_c, m_str, m_cstr, chk_on;
  logic [PW-1:0] p1_d = '0, m_data = '0;
  function automatic logic [PW-1:0] recon(logic [PW-1:0] b, logic [LANES*RW-1:0] r);
    logic [PW-1:0] o;
    int v;
    for (int k = 0; k < LANES; k++) begin
      v = int'(b[k*BD +: BD]) + int'($signed(r[k*RW +: RW]));
      v = v < 0 ? 0 : (v > 255 ? 255 : v);
      o[k*BD +: BD] = BD'(v);
    end
    return o;
  endfunction
  function automatic logic [LANES*RW-1:0] pk(int r3, int r2, int r1, int r0);
    return {RW'(r3), RW'(r2), RW'(r1), RW'(r0)};
  endfunction
  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  task automatic cyc(input bit rn, input bit ns, input bit s, input logic [LANES*RW-1:0] d,
                     input bit bs, input bit bc, input logic [PW-1:0] b);
    bit full, empty;
    logic [PW:0] e;
    RSTN = rn; NEWSLICE = ns; STROBEI = s; DATAI = d; BSTROBEI = bs; BCHROMAI = bc; BASEI = b;
    @(posedge CLK2);
    if (!rn || ns) begin
      mq.delete();
      {m_ov, m_un, p1_v, p1_c, m_str, m_cstr} = '0;
      m_data = '0;
    end else begin
      full = mq.size() == DEPTH;
      empty = mq.size() == 0;
      m_str = p1_v && !p1_c;
      m_cstr = p1_v && p1_c;
      if (p1_v) m_data = p1_d;
      p1_v = 0;
      if (s && !empty) begin
        e = mq.pop_front();
        p1_v = 1;
        p1_c = e[PW];
        p1_d = recon(e[PW-1:0], d);
      end
      if (s && empty) m_un = 1;
      if (bs && !full) mq.push_back({bc, b});
      if (bs && full) m_ov = 1;
    end
    @(negedge CLK2);
    chk_on = 1;
  endtask
  task automatic idle();
    cyc(1, 0, 0, '0, 0, 0, '0);
  endtask
  task automatic push(input bit c, input logic [PW-1:0] b);
    cyc(1, 0, 0, '0, 1, c, b);
  endtask
  task automatic res(input logic [LANES*RW-1:0] d);
    cyc(1, 0, 1, d, 0, 0, '0);
  endtask
  always @(negedge CLK2)
    if (chk_on) begin
      check("STROBEO", 64'(STROBEO), 64'(m_str));
      check("CSTROBEO", 64'(CSTROBEO), 64'(m_cstr));
      check("DATAO", 64'(DATAO), 64'(m_data));
      check("LEVELO", 64'(LEVELO), 64'(mq.size()));
      check("BREADYO", 64'(BREADYO), 64'(mq.size() != DEPTH));
      check("DREADYO", 64'(DREADYO), 64'(mq.size() != 0));
      check("OVFO", 64'(OVFO), 64'(m_ov));
      check("UNFO", 64'(UNFO), 64'(m_un));
    end
  initial begin
    cyc(0, 0, 0, '0, 0, 0, '0);
    cyc(0, 0, 1, '1, 1, 1, '1);
    check("rst_level", 64'(LEVELO), 0);
    check("rst_data", 64'(DATAO), 0);
    check("rst_bready", 64'(BREADYO), 1);
    check("rst_dready", 64'(DREADYO), 0);
    push(0, 32'h10101010);
    res(pk(5, 5, 5, 5));
    idle();
    check("add_strobe", 64'(STROBEO), 1);
    check("add_cstrobe", 64'(CSTROBEO), 0);
    check("add_data", 64'(DATAO), 64'h15151515);
    push(0, 32'hFA03807F);
    res(pk(10, -8, 0, -200));
    idle();
    check("clip_data", 64'(DATAO), 64'hFF008000);
    push(1, 32'h12345678);
    res(pk(0, 0, 0, 0));
    idle();
    check("chroma_cstrobe", 64'(CSTROBEO), 1);
    check("chroma_strobe", 64'(STROBEO), 0);
    check("chroma_data", 64'(DATAO), 64'h12345678);
    idle();
    check("hold_data", 64'(DATAO), 64'h12345678);
    for (int k = 0; k < DEPTH; k++) push(k[0], {4{8'(k*4)}});
    check("full_level", 64'(LEVELO), 64);
    check("full_bready", 64'(BREADYO), 0);
    push(0, 32'hDEADBEEF);
    check("ovf_set", 64'(OVFO), 1);
    check("ovf_level", 64'(LEVELO), 64);
    cyc(1, 0, 1, pk(1, 2, 3, 4), 1, 0, 32'hCAFEF00D);
    check("pushpop_full_level", 64'(LEVELO), 63);
    for (int k = 0; k < DEPTH - 1; k++) res(pk(k*8 - 250, k - 30, -k*3, 200 - k*6));
    check("drained_level", 64'(LEVELO), 0);
    idle();
    idle();
    res(pk(1, 1, 1, 1));
    check("unf_set", 64'(UNFO), 1);
    idle();
    check("unf_no_strobe", 64'(STROBEO | CSTROBEO), 0);
    cyc(1, 1, 0, '0, 0, 0, '0);
    check("slice_unf", 64'(UNFO), 0);
    check("slice_ovf", 64'(OVFO), 0);
    check("slice_level", 64'(LEVELO), 0);
    for (int k = 0; k < 4; k++) push(0, {4{8'(100 + k*20)}});
    for (int k = 0; k < 4; k++) res(pk(k, -k, 2*k, 50));
    check("stream_last_strobe", 64'(STROBEO), 1);
    cyc(1, 1, 0, '0, 0, 0, '0);
    check("slice_drop1", 64'(STROBEO | CSTROBEO), 0);
    check("slice_drop_data", 64'(DATAO), 0);
    idle();
    check("slice_drop2", 64'(STROBEO | CSTROBEO), 0);
    for (int k = 0; k < 3; k++) push(k[0], {4{8'(7 + k)}});
    res(pk(-3, 3, -3, 3));
    res(pk(9, 9, 9, 9));
    cyc(0, 0, 1, pk(1, 1, 1, 1), 1, 0, '1);
    check("rst_mid_strobe", 64'(STROBEO | CSTROBEO), 0);
    check("rst_mid_data", 64'(DATAO), 0);
    check("rst_mid_level", 64'(LEVELO), 0);
    idle();
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
